execute_stage: RTL and testbench

//  Execute stage directly downstream of the Read stage: consumes register operands, immediates and opcode fields.

---
 rtl/exec_pkg.sv | 60 ++++++
 rtl/execute_stage_if.sv | 21 ++
 rtl/exec_imul_iter.sv | 70 +++++++
 rtl/execute_stage.sv | 192 +++++++++++++++++++
 tb/tb_execute_stage.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared decode constants, op/state enums and flag bit positions for the execute stage.
package exec_pkg;

  localparam logic [7:0] OPC_ADD_MR  = 8'h01;
  localparam logic [7:0] OPC_ADD_RM  = 8'h03;
  localparam logic [7:0] OPC_SUB_MR  = 8'h29;
  localparam logic [7:0] OPC_SUB_RM  = 8'h2B;
  localparam logic [7:0] OPC_AND_MR  = 8'h21;
  localparam logic [7:0] OPC_AND_RM  = 8'h23;
  localparam logic [7:0] OPC_OR_MR   = 8'h09;
  localparam logic [7:0] OPC_OR_RM   = 8'h0B;
  localparam logic [7:0] OPC_XOR_MR  = 8'h31;
  localparam logic [7:0] OPC_XOR_RM  = 8'h33;
  localparam logic [7:0] OPC_MOV_MR  = 8'h89;
  localparam logic [7:0] OPC_MOV_RM  = 8'h8B;
  localparam logic [7:0] OPC_MOV_RI  = 8'hB8;
  localparam logic [7:0] OPC_MOV_MI  = 8'hC7;
  localparam logic [7:0] OPC_GRP1_IZ = 8'h81;
  localparam logic [7:0] OPC_GRP1_IB = 8'h83;
  localparam logic [7:0] OPC_GRP3    = 8'hF7;

  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_ZF = 1;
  localparam int unsigned FLAG_SF = 2;
  localparam int unsigned FLAG_OF = 3;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, MOV, IMUL, ILLEGAL} alu_op_e;
  typedef enum logic {IDLE, MUL} exec_state_e;

  function automatic alu_op_e decodeOp(input logic [7:0] opc, input logic [2:0] ext,
                                       input logic extValid);
    alu_op_e op;
    case (opc)
      OPC_ADD_MR, OPC_ADD_RM: op = ADD;
      OPC_SUB_MR, OPC_SUB_RM: op = SUB;
      OPC_AND_MR, OPC_AND_RM: op = AND;
      OPC_OR_MR,  OPC_OR_RM:  op = OR;
      OPC_XOR_MR, OPC_XOR_RM: op = XOR;
      OPC_MOV_MR, OPC_MOV_RM, OPC_MOV_MI: op = MOV;
      OPC_GRP1_IZ, OPC_GRP1_IB: begin
        if (!extValid) op = ILLEGAL;
        else begin
          case (ext)
            3'd0:    op = ADD;
            3'd1:    op = OR;
            3'd4:    op = AND;
            3'd5:    op = SUB;
            3'd6:    op = XOR;
            default: op = ILLEGAL;
          endcase
        end
      end
      OPC_GRP3: op = (extValid && ext == 3'd5) ? IMUL : ILLEGAL;
      // B8..BF encode the destination register in the low opcode bits
      default:  op = (opc[7:3] == OPC_MOV_RI[7:3]) ? MOV : ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Writeback-side result bus and valid/ready handshake of the execute stage.
interface execute_stage_if;
  logic        outValid;
  logic        outReady;
  logic [63:0] resultOut;
  logic [63:0] resultHiOut;
  logic [3:0]  destRegOut;
  logic [3:0]  destHiRegOut;
  logic        destHiValidOut;
  logic        writeEnOut;
  logic        illegalOut;
  logic [31:0] ripOut;
  logic [3:0]  flagsOut;

  modport master (output outValid, resultOut, resultHiOut, destRegOut, destHiRegOut,
                  destHiValidOut, writeEnOut, illegalOut, ripOut, flagsOut,
                  input outReady);
  modport slave  (input outValid, resultOut, resultHiOut, destRegOut, destHiRegOut,
                  destHiValidOut, writeEnOut, illegalOut, ripOut, flagsOut,
                  output outReady);
endinterface

// File: rtl/exec_imul_iter.sv
// Iterative signed 64x64->128 multiplier: shift-add on magnitudes, sign applied on output.
module exec_imul_iter #(
  parameter int unsigned MUL_BITS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         start,
  input  logic         abort,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         busy,
  output logic         done,
  output logic [127:0] product
);

  localparam int unsigned N     = 64 / MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  if (MUL_BITS_PER_CYCLE != 1 && MUL_BITS_PER_CYCLE != 2 &&
      MUL_BITS_PER_CYCLE != 4 && MUL_BITS_PER_CYCLE != 8) begin : g_badMulBits
    $error("MUL_BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  logic             busyQ;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     acc, mcand, nextAcc;
  logic [63:0]      mplier;

  always_comb begin
    nextAcc = acc;
    for (int unsigned i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (mplier[i]) nextAcc = nextAcc + (mcand << i);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busyQ  <= 1'b0;
      neg    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      busyQ <= 1'b0;
    end else if (start) begin
      busyQ  <= 1'b1;
      neg    <= a[63] ^ b[63];
      cnt    <= CNT_W'(N);
      acc    <= '0;
      mcand  <= {64'd0, (a[63] ? -a : a)};
      mplier <= b[63] ? -b : b;
    end else if (busyQ) begin
      if (cnt == '0) begin
        busyQ <= 1'b0;
      end else begin
        acc    <= nextAcc;
        mcand  <= mcand << MUL_BITS_PER_CYCLE;
        mplier <= mplier >> MUL_BITS_PER_CYCLE;
        cnt    <= cnt - 1'b1;
      end
    end
  end

  assign busy    = busyQ;
  assign done    = busyQ && (cnt == '0);
  assign product = neg ? -acc : acc;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: decode, operand select, single-cycle ALU, iterative IMUL, one-entry output register.
// Define EXEC_FLAGS_EN to compute flagsOut {OF,SF,ZF,CF}; otherwise flagsOut is tied to zero.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        flushIn,
  input  logic        validIn,
  output logic        stallOut,
  input  logic [7:0]  opcodeIn,
  input  logic [2:0]  extendedOpcodeIn,
  input  logic [31:0] hasExtendedOpcodeIn,
  input  logic [63:0] operandVal1In,
  input  logic [63:0] operandVal2In,
  input  logic [31:0] immLenIn,
  input  logic [7:0]  imm8In,
  input  logic [15:0] imm16In,
  input  logic [31:0] imm32In,
  input  logic [63:0] imm64In,
  input  logic [3:0]  destRegIn,
  input  logic [3:0]  destRegisterSpecialIn,
  input  logic [31:0] currentRipIn,
  execute_stage_if.master wb
);

  exec_state_e  state, stateNext;
  alu_op_e      aluOp;
  logic         readyOut, accept, mulStart, mulBusy, mulDone, immIllegal;
  logic [63:0]  opA, opB, aluRes;
  logic [127:0] mulProduct;
  logic [3:0]   aluFlags, mulFlags;
  logic [3:0]   pendDest, pendDestHi;
  logic [31:0]  pendRip;

  assign readyOut = (state == IDLE) && (!wb.outValid || wb.outReady);
  assign stallOut = !readyOut;
  assign accept   = validIn && readyOut && !flushIn;
  assign opA      = operandVal1In;
  assign mulStart = accept && (aluOp == IMUL);

  always_comb begin
    opB        = operandVal2In;
    immIllegal = 1'b0;
    case (immLenIn)
      32'd0:   opB = operandVal2In;
      32'd1:   opB = {{56{imm8In[7]}}, imm8In};
      32'd2:   opB = {{48{imm16In[15]}}, imm16In};
      32'd4:   opB = {{32{imm32In[31]}}, imm32In};
      32'd8:   opB = imm64In;
      default: immIllegal = 1'b1;
    endcase
  end

  assign aluOp = immIllegal ? ILLEGAL
                            : decodeOp(opcodeIn, extendedOpcodeIn, |hasExtendedOpcodeIn);

  always_comb begin
    aluRes = '0;
    case (aluOp)
      ADD:     aluRes = opA + opB;
      SUB:     aluRes = opA - opB;
      AND:     aluRes = opA & opB;
      OR:      aluRes = opA | opB;
      XOR:     aluRes = opA ^ opB;
      MOV:     aluRes = opB;
      default: aluRes = '0;
    endcase
  end

`ifdef EXEC_FLAGS_EN
  logic [64:0] sum65, diff65;

  always_comb begin
    sum65    = {1'b0, opA} + {1'b0, opB};
    diff65   = {1'b0, opA} - {1'b0, opB};
    aluFlags = '0;
    case (aluOp)
      ADD: begin
        aluFlags[FLAG_CF] = sum65[64];
        aluFlags[FLAG_OF] = (opA[63] == opB[63]) && (sum65[63] != opA[63]);
      end
      SUB: begin
        aluFlags[FLAG_CF] = diff65[64];
        aluFlags[FLAG_OF] = (opA[63] != opB[63]) && (diff65[63] != opA[63]);
      end
      default: ;
    endcase
    if (aluOp inside {ADD, SUB, AND, OR, XOR}) begin
      aluFlags[FLAG_ZF] = (aluRes == '0);
      aluFlags[FLAG_SF] = aluRes[63];
    end
  end

  always_comb begin
    mulFlags          = '0;
    mulFlags[FLAG_CF] = mulProduct[127:64] != {64{mulProduct[63]}};
    mulFlags[FLAG_OF] = mulFlags[FLAG_CF];
    mulFlags[FLAG_ZF] = (mulProduct[63:0] == '0);
    mulFlags[FLAG_SF] = mulProduct[63];
  end
`else
  assign aluFlags = '0;
  assign mulFlags = '0;
`endif

  exec_imul_iter #(.MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)) uImul (
    .clk     (clk),
    .resetN  (resetN),
    .start   (mulStart),
    .abort   (flushIn),
    .a       (opA),
    .b       (opB),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulProduct)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flushIn) stateNext = IDLE;
    else begin
      case (state)
        IDLE:    if (mulStart) stateNext = MUL;
        MUL:     if (mulDone || !mulBusy) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // IMUL destination/rip are captured at accept since Read moves on while the multiplier runs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pendDest   <= '0;
      pendDestHi <= '0;
      pendRip    <= '0;
    end else if (mulStart) begin
      pendDest   <= destRegIn;
      pendDestHi <= destRegisterSpecialIn;
      pendRip    <= currentRipIn;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wb.outValid       <= 1'b0;
      wb.resultOut      <= '0;
      wb.resultHiOut    <= '0;
      wb.destRegOut     <= '0;
      wb.destHiRegOut   <= '0;
      wb.destHiValidOut <= 1'b0;
      wb.writeEnOut     <= 1'b0;
      wb.illegalOut     <= 1'b0;
      wb.ripOut         <= '0;
      wb.flagsOut       <= '0;
    end else if (flushIn) begin
      wb.outValid <= 1'b0;
    end else if (accept && aluOp != IMUL) begin
      wb.outValid       <= 1'b1;
      wb.resultOut      <= aluRes;
      wb.resultHiOut    <= '0;
      wb.destRegOut     <= destRegIn;
      wb.destHiRegOut   <= '0;
      wb.destHiValidOut <= 1'b0;
      wb.writeEnOut     <= (aluOp != ILLEGAL);
      wb.illegalOut     <= (aluOp == ILLEGAL);
      wb.ripOut         <= currentRipIn;
      wb.flagsOut       <= aluFlags;
    end else if (state == MUL && mulDone) begin
      wb.outValid       <= 1'b1;
      wb.resultOut      <= mulProduct[63:0];
      wb.resultHiOut    <= mulProduct[127:64];
      wb.destRegOut     <= pendDest;
      wb.destHiRegOut   <= pendDestHi;
      wb.destHiValidOut <= 1'b1;
      wb.writeEnOut     <= 1'b1;
      wb.illegalOut     <= 1'b0;
      wb.ripOut         <= pendRip;
      wb.flagsOut       <= mulFlags;
    end else if (wb.outValid && wb.outReady) begin
      wb.outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed ALU/IMUL vectors, backpressure, flush and reset abort.
module tb_execute_stage;

  typedef struct {
    logic [7:0]  opc;
    logic [2:0]  ext;
    logic [31:0] hasExt;
    logic [63:0] op1, op2;
    logic [31:0] immLen;
    logic [63:0] imm;
    logic [3:0]  dest, destSp;
    logic [31:0] rip;
  } op_t;

  typedef struct {
    logic [63:0] res, hi;
    logic        hiValid, we, ill;
    logic [3:0]  flags, dest, destHi;
    logic [31:0] rip;
  } exp_t;

  typedef struct {
    op_t         o;
    logic [63:0] res;
    logic [3:0]  flg;
    logic        ill;
  } tv_t;

  logic clk = 1'b0;
  logic resetN, flushIn, validIn, stallOut;
  logic [7:0]  opcodeIn;
  logic [2:0]  extendedOpcodeIn;
  logic [31:0] hasExtendedOpcodeIn, immLenIn, imm32In, currentRipIn;
  logic [63:0] operandVal1In, operandVal2In, imm64In;
  logic [7:0]  imm8In;
  logic [15:0] imm16In;
  logic [3:0]  destRegIn, destRegisterSpecialIn;

  execute_stage_if wb();

  execute_stage #(.MUL_BITS_PER_CYCLE(4)) dut (
    .clk(clk), .resetN(resetN), .flushIn(flushIn), .validIn(validIn), .stallOut(stallOut),
    .opcodeIn(opcodeIn), .extendedOpcodeIn(extendedOpcodeIn),
    .hasExtendedOpcodeIn(hasExtendedOpcodeIn), .operandVal1In(operandVal1In),
    .operandVal2In(operandVal2In), .immLenIn(immLenIn), .imm8In(imm8In), .imm16In(imm16In),
    .imm32In(imm32In), .imm64In(imm64In), .destRegIn(destRegIn),
    .destRegisterSpecialIn(destRegisterSpecialIn), .currentRipIn(currentRipIn), .wb(wb)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];
  exp_t monE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [3:0] expF(input logic [3:0] f);
`ifdef EXEC_FLAGS_EN
    return f;
`else
    return 4'd0 & f;
`endif
  endfunction

  function automatic op_t mk(input logic [7:0] opc, input logic [2:0] ext, input logic [31:0] hasExt,
                             input logic [63:0] op1, input logic [63:0] op2,
                             input logic [31:0] immLen, input logic [63:0] imm,
                             input logic [3:0] dest, input logic [31:0] rip);
    op_t o;
    o.opc = opc; o.ext = ext; o.hasExt = hasExt; o.op1 = op1; o.op2 = op2;
    o.immLen = immLen; o.imm = imm; o.dest = dest; o.destSp = 4'd2; o.rip = rip;
    return o;
  endfunction

  function automatic exp_t aluExp(input op_t o, input logic [63:0] res, input logic [3:0] flg,
                                  input logic ill);
    exp_t e;
    e.res = ill ? 64'd0 : res; e.hi = '0; e.hiValid = 1'b0; e.we = !ill; e.ill = ill;
    e.flags = ill ? 4'd0 : expF(flg); e.dest = o.dest; e.destHi = '0; e.rip = o.rip;
    return e;
  endfunction

  function automatic exp_t mulExp(input op_t o, input logic [63:0] lo, input logic [63:0] hi,
                                  input logic [3:0] flg);
    exp_t e;
    e.res = lo; e.hi = hi; e.hiValid = 1'b1; e.we = 1'b1; e.ill = 1'b0;
    e.flags = expF(flg); e.dest = o.dest; e.destHi = o.destSp; e.rip = o.rip;
    return e;
  endfunction

  task automatic apply(input op_t o);
    opcodeIn = o.opc; extendedOpcodeIn = o.ext; hasExtendedOpcodeIn = o.hasExt;
    operandVal1In = o.op1; operandVal2In = o.op2; immLenIn = o.immLen;
    imm8In = o.imm[7:0]; imm16In = o.imm[15:0]; imm32In = o.imm[31:0]; imm64In = o.imm;
    destRegIn = o.dest; destRegisterSpecialIn = o.destSp; currentRipIn = o.rip;
  endtask

  // Returns #1 after the accepting clock edge
  task automatic sendOp(input op_t o);
    int n = 0;
    apply(o);
    validIn = 1'b1;
    #1;
    while (stallOut && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (stallOut) check("accept_timeout", 64'(stallOut), 64'd0);
    @(posedge clk); #1;
    validIn = 1'b0;
  endtask

  task automatic waitOut(output int n, output logic stallBad);
    n = 0; stallBad = 1'b0;
    while (!wb.outValid && n < 60) begin
      if (!stallOut) stallBad = 1'b1;
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic watchIdle(input string name, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      if (wb.outValid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  always @(negedge clk) begin
    if (resetN && wb.outValid && wb.outReady) begin
      if (expQ.size() == 0) begin
        check("unexpected_output", wb.resultOut, 64'hDEAD_0000_0000_0000 ^ ~wb.resultOut);
      end else begin
        monE = expQ.pop_front();
        check("resultOut", wb.resultOut, monE.res);
        check("resultHiOut", wb.resultHiOut, monE.hi);
        check("destHiValidOut", 64'(wb.destHiValidOut), 64'(monE.hiValid));
        check("writeEnOut", 64'(wb.writeEnOut), 64'(monE.we));
        check("illegalOut", 64'(wb.illegalOut), 64'(monE.ill));
        check("flagsOut", 64'(wb.flagsOut), 64'(monE.flags));
        check("ripOut", 64'(wb.ripOut), 64'(monE.rip));
        if (!monE.ill) check("destRegOut", 64'(wb.destRegOut), 64'(monE.dest));
        if (monE.hiValid) check("destHiRegOut", 64'(wb.destHiRegOut), 64'(monE.destHi));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  tv_t  tv[13];
  op_t  o;
  int   n;
  logic stallBad;

  initial begin
    tv[0]  = '{mk(8'h01, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 4'd1, 32'h100), 64'h8000_0000_0000_0000, 4'b1100, 1'b0};
    tv[1]  = '{mk(8'h83, 5, 1, 64'd0, 64'd0, 1, 64'hFF, 4'd3, 32'h104), 64'd1, 4'b0001, 1'b0};
    tv[2]  = '{mk(8'h81, 0, 1, 64'd1, 64'd0, 4, 64'hFFFF_FFFF, 4'd4, 32'h108), 64'd0, 4'b0011, 1'b0};
    tv[3]  = '{mk(8'h81, 1, 1, 64'd0, 64'd0, 2, 64'h8000, 4'd5, 32'h10C), 64'hFFFF_FFFF_FFFF_8000, 4'b0100, 1'b0};
    tv[4]  = '{mk(8'h21, 0, 0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 4'd6, 32'h110), 64'h0F00_0F00_0F00_0F00, 4'b0000, 1'b0};
    tv[5]  = '{mk(8'h0B, 0, 0, 64'h8000_0000_0000_0000, 64'd1, 0, 0, 4'd7, 32'h114), 64'h8000_0000_0000_0001, 4'b0100, 1'b0};
    tv[6]  = '{mk(8'hBB, 0, 0, 64'd9, 64'd9, 8, 64'h1122_3344_5566_7788, 4'd3, 32'h118), 64'h1122_3344_5566_7788, 4'b0000, 1'b0};
    tv[7]  = '{mk(8'h89, 0, 0, 64'd5, 64'd0, 0, 0, 4'd8, 32'h11C), 64'd0, 4'b0000, 1'b0};
    tv[8]  = '{mk(8'h29, 0, 0, 64'h8000_0000_0000_0000, 64'd1, 0, 0, 4'd9, 32'h120), 64'h7FFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
    tv[9]  = '{mk(8'h33, 0, 0, 64'h1234, 64'h1234, 0, 0, 4'd10, 32'h124), 64'd0, 4'b0010, 1'b0};
    tv[10] = '{mk(8'h01, 0, 0, 64'd1, 64'd2, 3, 0, 4'd11, 32'h128), 64'd0, 4'b0000, 1'b1};
    tv[11] = '{mk(8'h83, 5, 0, 64'd1, 64'd2, 1, 1, 4'd12, 32'h12C), 64'd0, 4'b0000, 1'b1};
    tv[12] = '{mk(8'h83, 7, 1, 64'd1, 64'd2, 1, 1, 4'd13, 32'h130), 64'd0, 4'b0000, 1'b1};

    resetN = 1'b0; flushIn = 1'b0; validIn = 1'b0; wb.outReady = 1'b1;
    apply(mk(8'h00, 0, 0, 0, 0, 0, 0, 4'd0, 0));
    #22 resetN = 1'b1;
    @(posedge clk); #1;

    check("rst_outValid", 64'(wb.outValid), 64'd0);
    check("rst_writeEn", 64'(wb.writeEnOut), 64'd0);
    check("rst_illegal", 64'(wb.illegalOut), 64'd0);
    check("rst_destHiValid", 64'(wb.destHiValidOut), 64'd0);
    check("rst_result", wb.resultOut, 64'd0);
    check("rst_resultHi", wb.resultHiOut, 64'd0);
    check("rst_flags", 64'(wb.flagsOut), 64'd0);
    check("rst_stall", 64'(stallOut), 64'd0);

    // ALU vectors back to back, each visible the cycle after accept
    for (int i = 0; i < 13; i++) begin
      expQ.push_back(aluExp(tv[i].o, tv[i].res, tv[i].flg, tv[i].ill));
      sendOp(tv[i].o);
      check("alu_latency1", 64'(wb.outValid), 64'd1);
    end
    @(posedge clk); #1;

    // IMUL -3 * 5
    o = mk(8'hF7, 5, 1, -64'sd3, 64'd5, 0, 0, 4'd0, 32'h200);
    expQ.push_back(mulExp(o, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100));
    sendOp(o);
    waitOut(n, stallBad);
    check("imul1_latency", 64'(n), 64'd17);
    check("imul1_stall", 64'(stallBad), 64'd0);
    @(posedge clk); #1;

    // IMUL 0x8000.. * -1 overflows the low half
    o = mk(8'hF7, 5, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 4'd0, 32'h204);
    expQ.push_back(mulExp(o, 64'h8000_0000_0000_0000, 64'd0, 4'b1101));
    sendOp(o);
    waitOut(n, stallBad);
    check("imul2_latency", 64'(n), 64'd17);
    check("imul2_stall", 64'(stallBad), 64'd0);
    @(posedge clk); #1;

    // Backpressure: hold result, then replace it in the cycle ready returns
    wb.outReady = 1'b0;
    o = mk(8'h03, 0, 0, 64'd5, 64'd6, 0, 0, 4'd1, 32'h300);
    expQ.push_back(aluExp(o, 64'd11, 4'b0000, 1'b0));
    sendOp(o);
    repeat (5) begin
      check("hold_valid", 64'(wb.outValid), 64'd1);
      check("hold_result", wb.resultOut, 64'd11);
      check("hold_stall", 64'(stallOut), 64'd1);
      @(posedge clk); #1;
    end
    o = mk(8'h31, 0, 0, 64'hF0F0, 64'hFF00, 0, 0, 4'd2, 32'h304);
    expQ.push_back(aluExp(o, 64'h0FF0, 4'b0000, 1'b0));
    apply(o);
    validIn = 1'b1; wb.outReady = 1'b1;
    #1;
    check("bp_ready_same_cycle", 64'(stallOut), 64'd0);
    @(posedge clk); #1;
    validIn = 1'b0;
    check("bp_new_valid", 64'(wb.outValid), 64'd1);
    check("bp_new_result", wb.resultOut, 64'h0FF0);
    @(posedge clk); #1;

    // Flush during MUL cycle 4 with a competing validIn
    sendOp(mk(8'hF7, 5, 1, 64'd7, 64'd9, 0, 0, 4'd0, 32'h400));
    repeat (3) begin @(posedge clk); #1; end
    apply(mk(8'h01, 0, 0, 64'd1, 64'd1, 0, 0, 4'd3, 32'h404));
    flushIn = 1'b1; validIn = 1'b1;
    @(posedge clk); #1;
    flushIn = 1'b0; validIn = 1'b0;
    check("flush_idle", 64'(stallOut), 64'd0);
    watchIdle("flush_no_output", 25);

    // Flush while idle: same-cycle validIn must be dropped
    flushIn = 1'b1; validIn = 1'b1;
    @(posedge clk); #1;
    flushIn = 1'b0; validIn = 1'b0;
    check("flush_drops_valid", 64'(wb.outValid), 64'd0);

    // Async reset mid-IMUL
    sendOp(mk(8'hF7, 5, 1, 64'd3, 64'd4, 0, 0, 4'd0, 32'h500));
    repeat (5) begin @(posedge clk); #1; end
    resetN = 1'b0;
    #2;
    check("rst_mid_stall", 64'(stallOut), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b1;
    check("rst_mid_result", wb.resultOut, 64'd0);
    watchIdle("rst_no_output", 25);

    // Unknown opcode
    o = mk(8'h0F, 0, 0, 64'd1, 64'd2, 0, 0, 4'd4, 32'h600);
    expQ.push_back(aluExp(o, 64'd0, 4'b0000, 1'b1));
    sendOp(o);
    check("illegal_valid", 64'(wb.outValid), 64'd1);
    check("illegal_flag", 64'(wb.illegalOut), 64'd1);
    check("illegal_we", 64'(wb.writeEnOut), 64'd0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
